apb_arb_master: RTL and testbench
=================================

// Module: apb_arb_master
// PURPOSE
//  Shares one APB master port between NUM_REQ on-chip requesters.
//  - Round-robin arbitration of pending requests.
//  - Sequences each granted request through the APB IDLE/SETUP/ACCESS protocol.
//  - Returns read data or error status to the granted requester.
//  - Adds a wait-state timeout so a hung slave cannot lock up the bus.
// PARAMETERS
//  NUM_REQ     2   number of requesters (>=2)
//  ADDR_WIDTH  32  paddr / req_addr width per requester
//  DATA_WIDTH  32  pwdata / prdata / req_wdata width
//  TIMEOUT     16  max ACCESS cycles with pready=0 before forced error; 0 = disabled
// PORTS
//  pclk        in   1                   clock; all logic on rising edge
//  presetn     in   1                   synchronous reset, active low
//  req_valid   in   NUM_REQ             request pending, per requester
//  req_write   in   NUM_REQ             1 = write, 0 = read
//  req_addr    in   NUM_REQ*ADDR_WIDTH  packed addresses; requester i at [i*AW +: AW]
//  req_wdata   in   NUM_REQ*DATA_WIDTH  packed write data; requester i at [i*DW +: DW]
//  req_ready   out  NUM_REQ             one-hot 1-cycle pulse: request accepted
//  rsp_valid   out  NUM_REQ             one-hot 1-cycle pulse: transfer complete
//  rsp_rdata   out  DATA_WIDTH          read data, valid with rsp_valid (0 for writes)
//  rsp_err     out  1                   pslverr or timeout, valid with rsp_valid
//  pready      in   1                   APB slave ready
//  pslverr     in   1                   APB slave error
//  prdata      in   DATA_WIDTH          APB read data
//  pselx       out  1                   APB select
//  penable     out  1                   APB enable
//  pwrite      out  1                   APB direction
//  paddr       out  ADDR_WIDTH          APB address
//  pwdata      out  DATA_WIDTH          APB write data
// BEHAVIOUR
//  Reset (presetn=0, sampled at pclk):
//   - All outputs 0; state IDLE; wait counter 0.
//   - Round-robin pointer set so requester 0 has priority on the first grant.
//   - Reset is effective in any state; an in-flight transfer is abandoned and no rsp_valid is issued.
//  FSM, all outputs registered:
//   - IDLE:
//     - If any req_valid, grant winner g, pulse req_ready[g], latch pwrite/paddr/pwdata from slot g, go to SETUP.
//     - Else remain in IDLE with pselx=0, penable=0.
//   - SETUP: pselx=1, penable=0; unconditionally go to ACCESS.
//   - ACCESS: pselx=1, penable=1; wait counter increments every cycle pready=0.
//     - pready=1: pulse rsp_valid[g]; rsp_rdata = pwrite ? 0 : prdata; rsp_err = pslverr.
//       - If any req_valid in the same cycle: arbitrate, pulse req_ready, relatch, go to SETUP (no IDLE bubble).
//       - Else go to IDLE.
//     - Timeout: TIMEOUT!=0 and counter reaches TIMEOUT with pready still 0:
//       - Pulse rsp_valid[g] with rsp_err=1, rsp_rdata=0.
//       - Go to IDLE; pselx=0, penable=0.
//     - Wait counter clears on every exit from ACCESS.
//   - Unused encoding: return to IDLE, outputs 0.
//  Handshake and data rules:
//   - pwrite, paddr and pwdata stay stable from SETUP until ACCESS completes; they hold their last value while IDLE.
//   - Requester holds req_valid and payload stable until it sees req_ready.
//   - At most one outstanding transfer; req_ready is never asserted while a transfer is in flight, except at completion.
//  Arbitration:
//   - Search starts at (last_grant+1) mod NUM_REQ, first valid wins.
//   - Simultaneous requests are served in rotating order; no requester starves.
//  Latency (no wait states): request accepted cycle T -> SETUP at T+1 -> ACCESS at T+2 -> rsp_valid at T+3.
//   - Back-to-back transfers occupy 2 cycles each.
// TESTING
//  1. Write req0, addr 0x10, wdata 0xA5A50001, pready=1
//     -> pselx=1/penable=0, then pselx=1/penable=1, pwrite=1, paddr=0x10; rsp_valid[0] with rsp_err=0.
//  2. Read req1, addr 0x24, pready low 3 cycles then high, prdata=0xDEADBEEF
//     -> penable high 4 cycles, paddr stable; rsp_rdata=0xDEADBEEF, rsp_err=0.
//  3. req0 and req1 both held valid for 6 transfers -> grants 0,1,0,1,0,1; ACCESS->SETUP with no IDLE cycle.
//  4. Read completes with pready=1, pslverr=1 -> rsp_err=1 for that requester only; next transfer unaffected.
//  5. TIMEOUT=16, pready held 0 -> after 16 ACCESS cycles: rsp_valid with rsp_err=1, rsp_rdata=0; pselx=0 next cycle.
//  6. presetn=0 for 1 cycle during ACCESS -> all outputs 0 next cycle, no rsp_valid; with both requesters valid, first grant goes to req0.

Source files
------------

// File: rtl/apb_arb_master.sv
// apb_arb_master
// Shares one APB master port between NUM_REQ on-chip requesters. Pending requests are
// arbitrated round-robin. Each granted request is sequenced through APB SETUP/ACCESS,
// and the response is returned to the requester that was granted. A wait-state timeout
// ends any transfer whose slave never raises pready.
//
// Ports
//   pclk_i        clock, rising edge
//   presetn_i     synchronous reset, active low
//   req_valid_i   per-requester request pending
//   req_write_i   per-requester direction (1 = write)
//   req_addr_i    packed addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   req_wdata_i   packed write data, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready_o   one-hot 1-cycle pulse: request accepted
//   rsp_valid_o   one-hot 1-cycle pulse: transfer complete
//   rsp_rdata_o   read data with rsp_valid_o (0 for writes and timeouts)
//   rsp_err_o     pslverr or timeout, with rsp_valid_o
//   pready_i, pslverr_i, prdata_i                       APB slave response
//   pselx_o, penable_o, pwrite_o, paddr_o, pwdata_o     APB master request

module apb_arb_master #(
    parameter int unsigned NUM_REQ    = 2,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic                          pclk_i,
    input  logic                          presetn_i,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ-1:0]            req_write_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    output logic [NUM_REQ-1:0]            rsp_valid_o,
    output logic [DATA_WIDTH-1:0]         rsp_rdata_o,
    output logic                          rsp_err_o,
    input  logic                          pready_i,
    input  logic                          pslverr_i,
    input  logic [DATA_WIDTH-1:0]         prdata_i,
    output logic                          pselx_o,
    output logic                          penable_o,
    output logic                          pwrite_o,
    output logic [ADDR_WIDTH-1:0]         paddr_o,
    output logic [DATA_WIDTH-1:0]         pwdata_o
);

    localparam int unsigned GntW         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CntW         = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam int unsigned TimeoutLastI = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
    localparam logic [CntW-1:0]    TimeoutLast = CntW'(TimeoutLastI);
    localparam logic [NUM_REQ-1:0] OneHot0     = NUM_REQ'(1);

    typedef enum logic [1:0] {
        StIdle   = 2'b00,
        StSetup  = 2'b01,
        StAccess = 2'b10
    } state_e;

    state_e                  state_q, state_d;
    logic [GntW-1:0]         grant_q, grant_d;
    logic [CntW-1:0]         cnt_q, cnt_d;
    logic                    pselx_q, pselx_d;
    logic                    penable_q, penable_d;
    logic                    pwrite_q, pwrite_d;
    logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
    logic [DATA_WIDTH-1:0]   pwdata_q, pwdata_d;
    logic [NUM_REQ-1:0]      req_ready_q, req_ready_d;
    logic [NUM_REQ-1:0]      rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                    rsp_err_q, rsp_err_d;

    logic                    arb_found;
    logic [GntW-1:0]         arb_idx;
    logic [GntW-1:0]         arb_cand;
    logic                    do_grant;

    // Round-robin: scan from the slot after the last grant, first valid wins.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = grant_q;
        arb_cand  = grant_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            arb_cand = GntW'((32'(grant_q) + 32'(i) + 32'd1) % NUM_REQ);
            if (!arb_found && req_valid_i[arb_cand]) begin
                arb_found = 1'b1;
                arb_idx   = arb_cand;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        cnt_d       = cnt_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        req_ready_d = '0;
        rsp_valid_d = '0;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;
        do_grant    = 1'b0;

        case (state_q)
            StIdle: begin
                if (arb_found) begin
                    do_grant = 1'b1;
                    state_d  = StSetup;
                end
            end
            StSetup: begin
                state_d = StAccess;
            end
            StAccess: begin
                if (pready_i) begin
                    rsp_valid_d = OneHot0 << grant_q;
                    rsp_rdata_d = pwrite_q ? '0 : prdata_i;
                    rsp_err_d   = pslverr_i;
                    cnt_d       = '0;
                    // Chain straight into the next SETUP when someone is waiting.
                    if (arb_found) begin
                        do_grant = 1'b1;
                        state_d  = StSetup;
                    end else begin
                        state_d = StIdle;
                    end
                end else if ((TIMEOUT != 0) && (cnt_q == TimeoutLast)) begin
                    // This is the TIMEOUT-th wait cycle: give up with an error.
                    rsp_valid_d = OneHot0 << grant_q;
                    rsp_err_d   = 1'b1;
                    cnt_d       = '0;
                    state_d     = StIdle;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase

        if (do_grant) begin
            grant_d     = arb_idx;
            req_ready_d = OneHot0 << arb_idx;
            pwrite_d    = req_write_i[arb_idx];
            paddr_d     = req_addr_i[arb_idx*ADDR_WIDTH +: ADDR_WIDTH];
            pwdata_d    = req_wdata_i[arb_idx*DATA_WIDTH +: DATA_WIDTH];
        end

        pselx_d   = (state_d == StSetup) || (state_d == StAccess);
        penable_d = (state_d == StAccess);
    end

    always_ff @(posedge pclk_i) begin
        if (!presetn_i) begin
            state_q     <= StIdle;
            grant_q     <= GntW'(NUM_REQ - 1);  // first search starts at requester 0
            cnt_q       <= '0;
            pselx_q     <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            req_ready_q <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            cnt_q       <= cnt_d;
            pselx_q     <= pselx_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign pselx_o     = pselx_q;
    assign penable_o   = penable_q;
    assign pwrite_o    = pwrite_q;
    assign paddr_o     = paddr_q;
    assign pwdata_o    = pwdata_q;
    assign req_ready_o = req_ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_apb_arb_master.sv
// Bench for apb_arb_master: table-driven single transfers plus hand-written sequences
// for back-to-back arbitration, timeout and reset during ACCESS. Expected responses are
// queued when a request is issued and popped by a monitor when rsp_valid pulses.

module tb_apb_arb_master;

    localparam int NR = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 16;

    logic             pclk;
    logic             presetn;
    logic [NR-1:0]    req_valid;
    logic [NR-1:0]    req_write;
    logic [NR*AW-1:0] req_addr;
    logic [NR*DW-1:0] req_wdata;
    logic [NR-1:0]    req_ready;
    logic [NR-1:0]    rsp_valid;
    logic [DW-1:0]    rsp_rdata;
    logic             rsp_err;
    logic             pready;
    logic             pslverr;
    logic [DW-1:0]    prdata;
    logic             pselx;
    logic             penable;
    logic             pwrite;
    logic [AW-1:0]    paddr;
    logic [DW-1:0]    pwdata;

    apb_arb_master #(
        .NUM_REQ   (NR),
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .TIMEOUT   (TO)
    ) dut (
        .pclk_i     (pclk),
        .presetn_i  (presetn),
        .req_valid_i(req_valid),
        .req_write_i(req_write),
        .req_addr_i (req_addr),
        .req_wdata_i(req_wdata),
        .req_ready_o(req_ready),
        .rsp_valid_o(rsp_valid),
        .rsp_rdata_o(rsp_rdata),
        .rsp_err_o  (rsp_err),
        .pready_i   (pready),
        .pslverr_i  (pslverr),
        .prdata_i   (prdata),
        .pselx_o    (pselx),
        .penable_o  (penable),
        .pwrite_o   (pwrite),
        .paddr_o    (paddr),
        .pwdata_o   (pwdata)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    typedef struct {
        int          req;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          waits;
        logic        slverr;
        logic [31:0] prdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    typedef struct {
        int          idx;
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    rsp_t sb[$];
    rsp_t mon_e;
    vec_t vecs[6];
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Response monitor: every rsp_valid pulse must match the oldest queued expectation.
    always @(negedge pclk) begin
        if (rsp_valid != '0) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_rsp: got rsp_valid=%b expected none", rsp_valid);
            end else begin
                mon_e = sb.pop_front();
                chk("rsp_valid", 64'(rsp_valid), 64'(1 << mon_e.idx));
                chk("rsp_rdata", 64'(rsp_rdata), 64'(mon_e.rdata));
                chk("rsp_err", 64'(rsp_err), 64'(mon_e.err));
            end
        end
    end

    task automatic check_zero(input string tag);
        chk({tag, "_pselx_penable"}, 64'({pselx, penable}), 64'd0);
        chk({tag, "_pwrite"}, 64'(pwrite), 64'd0);
        chk({tag, "_paddr"}, 64'(paddr), 64'd0);
        chk({tag, "_pwdata"}, 64'(pwdata), 64'd0);
        chk({tag, "_req_ready"}, 64'(req_ready), 64'd0);
        chk({tag, "_rsp"}, 64'({rsp_valid, rsp_err, rsp_rdata}), 64'd0);
    endtask

    // Wait (bounded) for a req_ready pulse, then compare it.
    task automatic wait_ready(input string name, input logic [NR-1:0] exp);
        bit got;
        got = 1'b0;
        for (int k = 0; k < 6 && !got; k++) begin
            @(negedge pclk);
            if (req_ready != '0) got = 1'b1;
        end
        chk(name, 64'(req_ready), 64'(exp));
    endtask

    task automatic run_vec(input vec_t v);
        int r;
        int cnt;
        bit done;
        r = v.req;
        @(posedge pclk);
        #1;
        req_valid[r]            = 1'b1;
        req_write[r]            = v.wr;
        req_addr[r*AW +: AW]    = v.addr;
        req_wdata[r*DW +: DW]   = v.wdata;
        sb.push_back('{v.req, v.exp_rdata, v.exp_err});
        wait_ready("vec_req_ready", NR'(1 << r));
        chk("setup_psel_pen", 64'({pselx, penable}), 64'b10);
        chk("setup_pwrite", 64'(pwrite), 64'(v.wr));
        chk("setup_paddr", 64'(paddr), 64'(v.addr));
        chk("setup_pwdata", 64'(pwdata), 64'(v.wdata));
        @(posedge pclk);
        #1;
        req_valid[r] = 1'b0;
        cnt  = 0;
        done = 1'b0;
        while (!done && cnt <= v.waits) begin
            @(negedge pclk);
            chk("access_psel_pen", 64'({pselx, penable}), 64'b11);
            chk("access_paddr", 64'(paddr), 64'(v.addr));
            if (cnt == v.waits) begin
                pready  = 1'b1;
                pslverr = v.slverr;
                prdata  = v.prdata;
                done    = 1'b1;
            end
            cnt++;
        end
        @(posedge pclk);
        #1;
        pready  = 1'b0;
        pslverr = 1'b0;
        @(negedge pclk);
        chk("idle_psel_pen", 64'({pselx, penable}), 64'b00);
        chk("idle_paddr_hold", 64'(paddr), 64'(v.addr));
    endtask

    task automatic do_reset();
        @(posedge pclk);
        #1;
        presetn   = 1'b0;
        req_valid = '0;
        pready    = 1'b0;
        pslverr   = 1'b0;
        @(posedge pclk);
        @(negedge pclk);
        check_zero("reset");
        @(posedge pclk);
        #1;
        presetn = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int grants;
        int cnt;
        bit done;

        presetn   = 1'b0;
        req_valid = '0;
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;
        pready    = 1'b0;
        pslverr   = 1'b0;
        prdata    = '0;

        //            req wr    addr           wdata          waits err   prdata         exp_rdata      exp_err
        vecs[0] = '{0, 1'b1, 32'h0000_0010, 32'hA5A5_0001, 0,  1'b0, 32'h7777_7777, 32'h0000_0000, 1'b0};
        vecs[1] = '{1, 1'b0, 32'h0000_0024, 32'h1111_1111, 3,  1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0};
        vecs[2] = '{0, 1'b0, 32'h0000_0030, 32'h2222_2222, 0,  1'b1, 32'h1111_2222, 32'h1111_2222, 1'b1};
        vecs[3] = '{1, 1'b1, 32'h0000_0044, 32'h5555_AAAA, 0,  1'b0, 32'h1234_5678, 32'h0000_0000, 1'b0};
        vecs[4] = '{1, 1'b1, 32'h0000_0048, 32'h0F0F_0F0F, 2,  1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
        vecs[5] = '{0, 1'b0, 32'hFFFF_FFFC, 32'h3333_3333, 15, 1'b0, 32'h0BAD_F00D, 32'h0BAD_F00D, 1'b0};

        do_reset();
        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Both requesters held valid: strict alternation, no IDLE bubble.
        do_reset();
        pready   = 1'b1;
        prdata   = 32'hCAFE_0001;
        req_addr = {32'h0000_0200, 32'h0000_0100};
        @(posedge pclk);
        #1;
        req_write = '0;
        req_valid = 2'b11;
        grants    = 0;
        for (int k = 0; k < 40 && grants < 6; k++) begin
            @(negedge pclk);
            if (grants > 0) chk("b2b_pselx", 64'(pselx), 64'd1);
            if (req_ready != '0) begin
                chk("b2b_grant", 64'(req_ready), (grants % 2 == 0) ? 64'd1 : 64'd2);
                chk("b2b_paddr", 64'(paddr), (grants % 2 == 0) ? 64'h100 : 64'h200);
                sb.push_back('{grants % 2, 32'hCAFE_0001, 1'b0});
                grants++;
            end
        end
        chk("b2b_grant_count", 64'(grants), 64'd6);
        @(posedge pclk);
        #1;
        req_valid = '0;
        repeat (4) @(negedge pclk);
        pready = 1'b0;

        // Hung slave: timeout after TO wait cycles with error and zero data.
        prdata = 32'hFFFF_FFFF;
        @(posedge pclk);
        #1;
        req_valid[0]   = 1'b1;
        req_write[0]   = 1'b0;
        req_addr[31:0] = 32'h0000_0080;
        sb.push_back('{0, 32'h0, 1'b1});
        wait_ready("to_req_ready", 2'b01);
        @(posedge pclk);
        #1;
        req_valid = '0;
        cnt  = 0;
        done = 1'b0;
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge pclk);
            if (penable) cnt++;
            else done = 1'b1;
        end
        chk("to_access_cycles", 64'(cnt), 64'(TO));
        chk("to_pselx_dropped", 64'(pselx), 64'd0);
        repeat (2) @(negedge pclk);

        // Reset during ACCESS: transfer abandoned, then req0 wins first grant.
        @(posedge pclk);
        #1;
        req_valid[1]    = 1'b1;
        req_write[1]    = 1'b0;
        req_addr[63:32] = 32'h0000_0300;
        wait_ready("rst_pre_req_ready", 2'b10);
        @(posedge pclk);
        #1;
        req_valid = '0;
        @(negedge pclk);
        chk("rst_in_access", 64'({pselx, penable}), 64'b11);
        @(posedge pclk);
        #1;
        presetn   = 1'b0;
        req_valid = 2'b11;
        req_addr  = {32'h0000_0300, 32'h0000_0400};
        @(posedge pclk);
        #1;
        presetn = 1'b1;
        @(negedge pclk);
        check_zero("rst_access");
        wait_ready("rst_first_grant", 2'b01);
        chk("rst_first_paddr", 64'(paddr), 64'h400);
        sb.push_back('{0, 32'h600D_600D, 1'b0});
        @(posedge pclk);
        #1;
        req_valid = '0;
        pready    = 1'b1;
        prdata    = 32'h600D_600D;
        @(posedge pclk);
        #1;
        pready = 1'b0;
        repeat (4) @(negedge pclk);

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
